// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, FSM encodings and register-field helpers for the 8-bit five-stage CPU.
package cpu_pkg;
  localparam int REG_AW = 3;
  localparam logic [3:0] OP_LD     = 4'd0;
  localparam logic [3:0] OP_ST     = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_ADDI   = 4'd3;
  localparam logic [3:0] OP_ALU_LO = 4'd4;
  localparam logic [3:0] OP_BEQ    = 4'd8;
  localparam logic [3:0] OP_J      = 4'd9;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_MWAIT = 2'd1, ST_HALT = 2'd2} state_t;
  function automatic logic uses_rs(input logic [3:0] op);
    return op <= OP_BEQ;
  endfunction
  function automatic logic uses_rt(input logic [3:0] op);
    return op == OP_ST || op == OP_ADD || (op >= OP_ALU_LO && op <= OP_BEQ);
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and branch-operand hazard decode for the ID stage.
module hazard_detect #(
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic [3:0]        i_id_op,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_idex_regwr,
  input  logic              i_idex_memrd,
  input  logic [REG_AW-1:0] i_idex_wreg,
  input  logic              i_exmem_memrd,
  input  logic [REG_AW-1:0] i_exmem_wreg,
  output logic              o_lu_haz,
  output logic              o_br_haz
);
  import cpu_pkg::*;
  logic w_rs_idex, w_rt_idex, w_beq;
  assign w_rs_idex = uses_rs(i_id_op) && i_idex_wreg == i_id_rs;
  assign w_rt_idex = uses_rt(i_id_op) && i_idex_wreg == i_id_rt;
  assign w_beq     = i_id_op == OP_BEQ;
  assign o_lu_haz  = i_idex_memrd && (w_rs_idex || w_rt_idex);
  // beq compares in ID, so it must wait for any in-flight ALU result and for a load until after MEM
  assign o_br_haz  = w_beq && ((i_idex_regwr && (i_idex_wreg == i_id_rs || i_idex_wreg == i_id_rt)) ||
                               (i_exmem_memrd && (i_exmem_wreg == i_id_rs || i_exmem_wreg == i_id_rt)));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline hazard/stall sequencer with memory-wait FSM, timeout halt
// and saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int REG_AW       = cpu_pkg::REG_AW,
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        id_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              idex_regwr,
  input  logic              idex_memrd,
  input  logic [REG_AW-1:0] idex_wreg,
  input  logic              exmem_memrd,
  input  logic [REG_AW-1:0] exmem_wreg,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  input  logic              br_taken,
  input  logic              perf_clr,
  output logic              ctrl_mux,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              pipe_hold,
  output logic              pcsrc_o,
  output logic              ifflush_o,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import cpu_pkg::*;
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WW-1:0] W_TO = WW'(WAIT_TIMEOUT);
  state_t r_state, w_state_n;
  logic [WW-1:0] r_wcnt, w_wcnt_n;
  logic [CNT_W-1:0] r_stall, r_flush;
  logic w_lu_haz, w_br_haz, w_haz, w_frz, w_go;
  hazard_detect #(.REG_AW(REG_AW)) u_hd (
    .i_id_op(id_op), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_idex_regwr(idex_regwr), .i_idex_memrd(idex_memrd), .i_idex_wreg(idex_wreg),
    .i_exmem_memrd(exmem_memrd), .i_exmem_wreg(exmem_wreg),
    .o_lu_haz(w_lu_haz), .o_br_haz(w_br_haz)
  );
  // an ack completes the access this cycle, so it never holds the pipeline
  assign w_frz = r_state == ST_HALT || (!dmem_ack && (r_state == ST_MWAIT || dmem_req));
  assign w_haz = w_lu_haz || w_br_haz;
  assign w_go  = !w_frz && !w_haz;
  assign pipe_hold = w_frz;
  assign ctrl_mux  = !w_frz && w_haz;
  assign pc_we     = w_go;
  assign ifid_we   = w_go;
  assign pcsrc_o   = w_go && br_taken;
  assign ifflush_o = w_go && br_taken;
  assign halted    = r_state == ST_HALT;
  assign stall_cnt = r_stall;
  assign flush_cnt = r_flush;
  always_comb begin
    w_state_n = r_state;
    w_wcnt_n  = r_wcnt;
    case (r_state)
      ST_RUN: if (dmem_req && !dmem_ack) begin
        w_state_n = ST_MWAIT;
        w_wcnt_n  = WW'(1);
      end
      ST_MWAIT: if (dmem_ack) begin
        w_state_n = ST_RUN;
        w_wcnt_n  = '0;
      end else if (r_wcnt == W_TO) w_state_n = ST_HALT;
      else w_wcnt_n = r_wcnt + 1'b1;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_wcnt  <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      r_state <= w_state_n;
      r_wcnt  <= w_wcnt_n;
      r_stall <= perf_clr ? '0 : (pipe_hold || ctrl_mux) && !(&r_stall) ? r_stall + 1'b1 : r_stall;
      r_flush <= perf_clr ? '0 : ifflush_o && !(&r_flush) ? r_flush + 1'b1 : r_flush;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scoreboard bench for hazard_stall_ctrl with narrow counters
// so that saturation is reachable in a few cycles.
module tb_hazard_stall_ctrl;
  localparam int CW = 4;
  localparam logic [6:0] RUNO  = 7'b0110000;
  localparam logic [6:0] BUB   = 7'b1000000;
  localparam logic [6:0] HOLD  = 7'b0001000;
  localparam logic [6:0] TAKEN = 7'b0110110;
  localparam logic [6:0] HALTO = 7'b0001001;
  logic clk = 0, rst_n;
  logic [3:0] id_op;
  logic [2:0] id_rs, id_rt, idex_wreg, exmem_wreg;
  logic idex_regwr, idex_memrd, exmem_memrd, dmem_req, dmem_ack, br_taken, perf_clr;
  logic ctrl_mux, pc_we, ifid_we, pipe_hold, pcsrc_o, ifflush_o, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0] obs;
  typedef struct {string tag; logic [6:0] o; logic [CW-1:0] s; logic [CW-1:0] f;} exp_t;
  exp_t sb[$];
  int nchk = 0, nfail = 0;
  logic [CW-1:0] m_stall = 0, m_flush = 0;
  hazard_stall_ctrl #(.REG_AW(3), .CNT_W(CW), .WAIT_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .idex_regwr(idex_regwr), .idex_memrd(idex_memrd), .idex_wreg(idex_wreg),
    .exmem_memrd(exmem_memrd), .exmem_wreg(exmem_wreg), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .br_taken(br_taken), .perf_clr(perf_clr),
    .ctrl_mux(ctrl_mux), .pc_we(pc_we), .ifid_we(ifid_we), .pipe_hold(pipe_hold),
    .pcsrc_o(pcsrc_o), .ifflush_o(ifflush_o), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  assign obs = {ctrl_mux, pc_we, ifid_we, pipe_hold, pcsrc_o, ifflush_o, halted};
  always #5 clk = ~clk;
  task automatic idle();
    id_op = 4'd2; id_rs = 3'd1; id_rt = 3'd1; idex_regwr = 0; idex_memrd = 0; idex_wreg = 3'd7;
    exmem_memrd = 0; exmem_wreg = 3'd7; dmem_req = 0; dmem_ack = 0; br_taken = 0; perf_clr = 0;
  endtask
  task automatic cyc(input string tag, input logic [6:0] e);
    exp_t x;
    x.tag = tag; x.o = e; x.s = m_stall; x.f = m_flush;
    sb.push_back(x);
    @(negedge clk);
    x = sb.pop_front();
    nchk++;
    assert (obs === x.o) else begin
      nfail++;
      $error("FAIL %s outs got %b exp %b", x.tag, obs, x.o);
    end
    nchk++;
    assert ({stall_cnt, flush_cnt} === {x.s, x.f}) else begin
      nfail++;
      $error("FAIL %s_cnt got stall=%0d flush=%0d exp stall=%0d flush=%0d", x.tag, stall_cnt, flush_cnt, x.s, x.f);
    end
    if (!rst_n || perf_clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if ((e[6] || e[3]) && m_stall != '1) m_stall++;
      if (e[1] && m_flush != '1) m_flush++;
    end
    @(posedge clk); #1;
  endtask
  initial begin
    rst_n = 0; idle();
    cyc("in_reset", RUNO);
    rst_n = 1;
    cyc("idle", RUNO);
    idex_regwr = 1; idex_memrd = 1; idex_wreg = 3'd2; id_op = 4'd2; id_rs = 3'd2; id_rt = 3'd5;
    cyc("lu_add", BUB);
    idle(); cyc("lu_after", RUNO);
    id_op = 4'd8; id_rs = 3'd3; id_rt = 3'd6; br_taken = 1;
    idex_regwr = 1; idex_memrd = 1; idex_wreg = 3'd3;
    cyc("ld_beq1", BUB);
    idex_regwr = 0; idex_memrd = 0; idex_wreg = 3'd0; exmem_memrd = 1; exmem_wreg = 3'd3;
    cyc("ld_beq2", BUB);
    exmem_memrd = 0; exmem_wreg = 3'd0;
    cyc("beq_taken", TAKEN);
    idle(); cyc("post_br", RUNO);
    id_op = 4'd8; id_rs = 3'd1; id_rt = 3'd6; idex_regwr = 1; idex_wreg = 3'd6;
    cyc("alu_beq", BUB);
    idex_regwr = 0; exmem_wreg = 3'd6;
    cyc("alu_beq_go", RUNO);
    idle(); id_op = 4'd3; id_rs = 3'd0; idex_memrd = 1; idex_wreg = 3'd0;
    cyc("r0_haz", BUB);
    id_rs = 3'd1; id_rt = 3'd0;
    cyc("addi_rt_unused", RUNO);
    idle(); dmem_req = 1;
    cyc("mw1", HOLD);
    idex_memrd = 1; idex_wreg = 3'd1; br_taken = 1;
    cyc("mw2_over_haz", HOLD);
    idle(); dmem_req = 1;
    cyc("mw3", HOLD);
    cyc("mw4", HOLD);
    dmem_ack = 1;
    cyc("mw_ack", RUNO);
    idle(); cyc("mw_done", RUNO);
    dmem_req = 1; dmem_ack = 1;
    cyc("zero_wait", RUNO);
    dmem_ack = 0; dmem_req = 0;
    cyc("zero_wait_run", RUNO);
    dmem_req = 1;
    cyc("rw1", HOLD);
    cyc("rw2", HOLD);
    rst_n = 0; m_stall = 0; m_flush = 0;
    cyc("rst_mid_wait", HOLD);
    rst_n = 1;
    cyc("req_reobs", HOLD);
    dmem_ack = 1;
    cyc("req_reobs_ack", RUNO);
    idle(); dmem_req = 1;
    for (int i = 0; i < 16; i++) cyc("to_hold", HOLD);
    cyc("halt", HALTO);
    dmem_req = 0; dmem_ack = 1; br_taken = 1;
    cyc("halt_sticky1", HALTO);
    dmem_ack = 0;
    cyc("halt_sticky2", HALTO);
    idle(); rst_n = 0; m_stall = 0; m_flush = 0;
    cyc("halt_reset", RUNO);
    rst_n = 1;
    cyc("after_halt", RUNO);
    id_op = 4'd2; id_rs = 3'd4; idex_memrd = 1; idex_regwr = 1; idex_wreg = 3'd4; br_taken = 1;
    cyc("br_vs_lu", BUB);
    id_op = 4'd9;
    cyc("j_no_bubble", TAKEN);
    id_op = 4'd10; br_taken = 0;
    cyc("op10_no_use", RUNO);
    id_op = 4'd4; id_rt = 3'd4; id_rs = 3'd0;
    for (int i = 0; i < 17; i++) cyc("sat_stall", BUB);
    cyc("sat_hold", BUB);
    perf_clr = 1;
    cyc("clr_in_stall", BUB);
    perf_clr = 0;
    cyc("after_clr", BUB);
    idle();
    cyc("final", RUNO);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
